// File: rtl/des_subkey_sched_if.sv
// Handshake bundle between the key register / control side and the DES
// subkey scheduler. The scheduler is the slave; whoever loads keys and
// consumes subkeys (the round engine side) is the master.
interface des_subkey_sched_if;
  logic        key_load;
  logic [1:64] key;
  logic        decrypt;
  logic        sk_ready;
  logic        sk_valid;
  logic [1:48] sk;
  logic [3:0]  sk_round;
  logic        sk_last;
  logic        busy;

  modport master (
    output key_load, key, decrypt, sk_ready,
    input  sk_valid, sk, sk_round, sk_last, busy
  );

  modport slave (
    input  key_load, key, decrypt, sk_ready,
    output sk_valid, sk, sk_round, sk_last, busy
  );
endinterface

// File: rtl/des_subkey_sched.sv
// Iterative DES key schedule. Holds the two 28-bit halves C and D and steps
// them one subkey per accepted handshake, rotating left for encryption
// (K1..K16) or right for decryption (K16..K1). The subkey itself is PC-2 of
// the current C/D registers, so it is stable whenever C/D are.
module des_subkey_sched (
  input  logic                       clk,
  input  logic                       rst_n,
  des_subkey_sched_if.slave          bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // Permuted choice 1: 64-bit key (parity bits dropped) to {C0, D0}.
  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: {C, D} to the 48-bit round subkey.
  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [4:0] LAST_STEP = 5'd16;

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    r = '0;
    for (int j = 0; j < 56; j++) begin
      r[j + 1] = k[PC1_TAB[j]];
    end
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] r;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      r[j + 1] = cd[PC2_TAB[j]];
    end
    return r;
  endfunction

  // Shift table SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  // Returns 1 when SH[n] is 2, 0 when SH[n] is 1.
  function automatic logic sh_is_two(input logic [4:0] n);
    logic two;
    case (n)
      5'd1, 5'd2, 5'd9, 5'd16: two = 1'b0;
      default:                 two = 1'b1;
    endcase
    return two;
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  state_t      r_state;
  logic [1:28] r_c;
  logic [1:28] r_d;
  logic [4:0]  r_step;
  logic        r_dir;

  state_t      w_state_nxt;
  logic [1:28] w_c_nxt;
  logic [1:28] w_d_nxt;
  logic [4:0]  w_step_nxt;
  logic        w_dir_nxt;
  logic [1:56] w_cd0;
  logic [4:0]  w_sh_idx;
  logic        w_sh_two;
  logic        w_xfer;
  logic        w_valid;

  assign w_valid = (r_state == S_RUN);
  assign w_xfer  = w_valid & bus.sk_ready;

  // Next-state and datapath update: key_load has priority over a transfer,
  // so a new key always restarts the schedule even mid-run.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_step_nxt  = r_step;
    w_dir_nxt   = r_dir;
    w_cd0       = pc1(bus.key);
    // Encrypt walks SH forward from entry i+1, decrypt walks it backward
    // from entry 17-i, undoing the rotation that produced the current step.
    w_sh_idx    = r_dir ? (5'd17 - r_step) : (r_step + 5'd1);
    w_sh_two    = sh_is_two(w_sh_idx);

    if (bus.key_load) begin
      // Decrypt starts at C0D0, which equals C16D16 because the shifts sum
      // to 28; encrypt needs the first single left rotation to reach K1.
      if (bus.decrypt) begin
        w_c_nxt = w_cd0[1:28];
        w_d_nxt = w_cd0[29:56];
      end else begin
        w_c_nxt = rotl(w_cd0[1:28], 1'b0);
        w_d_nxt = rotl(w_cd0[29:56], 1'b0);
      end
      w_step_nxt  = 5'd1;
      w_dir_nxt   = bus.decrypt;
      w_state_nxt = S_RUN;
    end else if (w_xfer) begin
      if (r_step == LAST_STEP) begin
        // C/D keep their final value; only the FSM returns to idle.
        w_state_nxt = S_IDLE;
      end else begin
        w_c_nxt    = r_dir ? rotr(r_c, w_sh_two) : rotl(r_c, w_sh_two);
        w_d_nxt    = r_dir ? rotr(r_d, w_sh_two) : rotl(r_d, w_sh_two);
        w_step_nxt = r_step + 5'd1;
      end
    end
  end

  // State register for the FSM and the C/D/step/direction datapath.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_step  <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Output decode. The 4-bit forms of step-1 and 16-step are exact for
  // steps 1..16, so only the low step bits are needed for the round index.
  assign bus.sk_valid = w_valid;
  assign bus.busy     = w_valid;
  assign bus.sk       = pc2({r_c, r_d});
  assign bus.sk_last  = w_valid & (r_step == LAST_STEP);
  assign bus.sk_round = !w_valid ? 4'd0 :
                        r_dir    ? (4'd0 - r_step[3:0]) :
                                   (r_step[3:0] - 4'd1);

endmodule

// File: tb/tb_des_subkey_sched.sv
// Self-checking bench for des_subkey_sched: directed golden vectors, abort,
// reset and parity cases, plus randomized keys and backpressure checked
// against a table-driven key-schedule model.
module tb_des_subkey_sched;

  logic clk;
  logic rst_n;

  des_subkey_sched_if bus ();

  des_subkey_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: Kn = PC-2(rotl(C0, S_n), rotl(D0, S_n)) where S_n is
  // the running sum of the shift table. Bit n (1-based, MSB first) of a
  // W-bit 0-based vector lives at index W-n.
  function automatic logic [27:0] rot_left(input logic [27:0] x, input int s);
    logic [55:0] t;
    t = {x, x};
    return t[55 - s -: 28];
  endfunction

  task automatic ref_sched(input logic [63:0] k, output logic [47:0] ks [16]);
    logic [55:0] cd0;
    logic [55:0] cd;
    logic [47:0] sk;
    int          total;
    for (int j = 0; j < 56; j++) cd0[55 - j] = k[64 - PC1[j]];
    total = 0;
    for (int n = 1; n <= 16; n++) begin
      total += SH[n];
      cd = {rot_left(cd0[55:28], total % 28), rot_left(cd0[27:0], total % 28)};
      for (int j = 0; j < 48; j++) sk[47 - j] = cd[56 - PC2[j]];
      ks[n - 1] = sk;
    end
  endtask

  // Drive a one-cycle key_load; returns at posedge+1 with the first subkey up.
  task automatic start(input logic [63:0] k, input logic dec);
    bus.key_load = 1'b1;
    bus.key      = k;
    bus.decrypt  = dec;
    @(posedge clk);
    #1;
    bus.key_load = 1'b0;
  endtask

  // Consume a full schedule, checking each presented subkey, index and last
  // flag against the model for model_key; records what was observed.
  task automatic collect(input string tag, input logic [63:0] model_key, input logic dec,
                         input bit rand_ready, output logic [47:0] obs [16]);
    logic [47:0] ks [16];
    int          idx;
    int          cycles;
    bit          rdy;
    ref_sched(model_key, ks);
    idx    = 0;
    cycles = 0;
    for (int i = 0; i < 16; i++) obs[i] = '0;
    while (idx < 16 && cycles < 400) begin
      rdy          = rand_ready ? bit'($urandom_range(0, 1)) : 1'b1;
      bus.sk_ready = rdy;
      check({tag, ".valid"}, 64'(bus.sk_valid), 64'd1);
      check({tag, ".sk"}, 64'(bus.sk), 64'(dec ? ks[15 - idx] : ks[idx]));
      check({tag, ".round"}, 64'(bus.sk_round), 64'(dec ? 15 - idx : idx));
      check({tag, ".last"}, 64'(bus.sk_last), 64'(idx == 15));
      obs[idx] = bus.sk;
      @(posedge clk);
      #1;
      if (rdy) idx++;
      cycles++;
    end
    if (idx < 16) check({tag, ".timeout"}, 64'(idx), 64'd16);
    bus.sk_ready = 1'b0;
    check({tag, ".end_valid"}, 64'(bus.sk_valid), 64'd0);
    check({tag, ".end_busy"}, 64'(bus.busy), 64'd0);
  endtask

  localparam logic [63:0] GKEY = 64'h133457799BBCDFF1;

  initial begin
    logic [47:0] obs [16];
    logic [63:0] k;
    logic [63:0] k2;

    bus.key_load = 1'b0;
    bus.key      = '0;
    bus.decrypt  = 1'b0;
    bus.sk_ready = 1'b0;
    rst_n        = 1'b0;
    #12;
    check("rst.valid", 64'(bus.sk_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.last", 64'(bus.sk_last), 64'd0);
    check("rst.round", 64'(bus.sk_round), 64'd0);
    check("rst.sk", 64'(bus.sk), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Golden encrypt run with ready held high.
    bus.sk_ready = 1'b1;
    check("enc.pre_valid", 64'(bus.sk_valid), 64'd0);
    start(GKEY, 1'b0);
    collect("enc", GKEY, 1'b0, 1'b0, obs);
    check("enc.K1", 64'(obs[0]), 64'h1B02EFFC7072);
    check("enc.K2", 64'(obs[1]), 64'h79AED9DBC9E5);
    check("enc.K16", 64'(obs[15]), 64'hCB3D8B0E17F5);

    // sk_ready level in idle must not wake the scheduler.
    bus.sk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("idle.valid", 64'(bus.sk_valid), 64'd0);
    end

    // Golden decrypt run.
    start(GKEY, 1'b1);
    collect("dec", GKEY, 1'b1, 1'b0, obs);
    check("dec.K16", 64'(obs[0]), 64'hCB3D8B0E17F5);
    check("dec.K15", 64'(obs[1]), 64'hBF918D3D3F0A);
    check("dec.K1", 64'(obs[15]), 64'h1B02EFFC7072);

    // Backpressure on the golden key.
    start(GKEY, 1'b0);
    collect("bp", GKEY, 1'b0, 1'b1, obs);

    // Abort at step 7 with a transfer on the same cycle.
    k2 = {$urandom, $urandom};
    bus.sk_ready = 1'b1;
    start(GKEY, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort.round_before", 64'(bus.sk_round), 64'd6);
    start(k2, 1'b1);
    check("abort.round_after", 64'(bus.sk_round), 64'd15);
    collect("abort", k2, 1'b1, 1'b0, obs);

    // Reset at step 5 clears outputs asynchronously.
    bus.sk_ready = 1'b1;
    start(GKEY, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid.round", 64'(bus.sk_round), 64'd4);
    rst_n = 1'b0;
    #1;
    check("mid_rst.valid", 64'(bus.sk_valid), 64'd0);
    check("mid_rst.busy", 64'(bus.busy), 64'd0);
    check("mid_rst.last", 64'(bus.sk_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst.valid", 64'(bus.sk_valid), 64'd0);
    end

    // Parity bits ignored: DUT gets flipped parity, model the original key.
    start(GKEY ^ 64'h0101010101010101, 1'b0);
    collect("parity", GKEY, 1'b0, 1'b0, obs);

    // Random keys, both directions, random backpressure.
    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom};
      start(k, 1'b0);
      collect("rnd_enc", k, 1'b0, 1'b1, obs);
      start(k, 1'b1);
      collect("rnd_dec", k, 1'b1, 1'b1, obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_subkey_sched.md
Name: des_subkey_sched

Overview:
- Iterative DES key-schedule generator.
- Produces the sixteen 48-bit round subkeys, one per handshake, in forward order (K1..K16) for encryption or reverse order (K16..K1) for decryption.
- Sits between the key register and the iterative Feistel round engine that feeds the S-box units.
- The decrypt direction is the complement of the encrypt schedule: right rotations instead of left rotations, reverse shift table.

Parameters:
- None. All widths are fixed by FIPS 46-3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  single-cycle pulse; captures key and decrypt, starts a schedule
- key  input  [1:64]  DES key; bit 1 is the MSB; parity bits 8,16,...,64 are ignored
- decrypt  input  1  0 = forward order K1..K16, 1 = reverse order K16..K1; sampled only with key_load
- sk_ready  input  1  round engine accepts the current subkey
- sk_valid  output  1  sk is valid
- sk  output  [1:48]  current subkey, PC-2(C,D), combinational from the C/D registers
- sk_round  output  [3:0]  index of the subkey on sk minus 1 (K1 -> 0, K16 -> 15)
- sk_last  output  1  high with sk_valid on the 16th transfer of a schedule
- busy  output  1  schedule in progress (state != IDLE)

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; C = 0, D = 0; step counter = 0; dir = 0.
  - Outputs: sk_valid = 0, sk_last = 0, busy = 0, sk_round = 0. sk = PC-2(0) = 0.
- Shift table SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The sum is 28, so C16D16 = C0D0.
- States:
  - IDLE: waiting for key_load.
  - RUN: presenting subkeys.
- key_load, in any state, including mid-schedule:
  - Load {C0,D0} = PC-1(key).
  - If decrypt = 0: register C = rotl(C0, 1), D = rotl(D0, 1). This is K1.
  - If decrypt = 1: register C = C0, D = D0. This is K16.
  - Step counter = 1; dir = decrypt; state = RUN.
  - An aborted schedule is discarded silently; no partial-completion flag is raised.
- Latency: sk_valid rises the cycle after key_load. The first subkey is available 1 cycle after load.
- In RUN:
  - sk_valid = 1.
  - Transfer occurs on a cycle with sk_valid & sk_ready.
  - Without sk_ready, C, D, the step counter and sk hold stable. There is no bubble, and the subkey must not change while unaccepted.
- On a transfer at step i (1 <= i <= 15):
  - Encrypt: C,D rotate left by SH[i+1].
  - Decrypt: C,D rotate right by SH[17-i].
  - Step counter = i+1.
  - Back-to-back transfers give one subkey per cycle.
- On a transfer at step 16: state = IDLE, sk_valid = 0 next cycle. C/D hold their final value.
- sk_round:
  - Encrypt: step - 1.
  - Decrypt: 16 - step.
- sk_last = sk_valid & (step == 16).
- Rotations are on each 28-bit half independently, with wrap-around (bit 1 moves to bit 28 on rotl).
- key_load coincident with a transfer: key_load wins. The transfer is accepted by the consumer, but the scheduler restarts from the new key.
- A sk_ready level in IDLE is ignored.
- Reset asserted mid-schedule: immediate return to reset values. No subkey is emitted after rst_n rises until a new key_load.

Test Plan:
- Reset, then key_load with key = 0x133457799BBCDFF1, decrypt = 0, sk_ready = 1 continuously:
  - sk_valid rises 1 cycle later; 16 consecutive valid cycles.
  - K1 = 0x1B02EFFC7072, K2 = 0x79AED9DBC9E5, K16 = 0xCB3D8B0E17F5.
  - sk_last only on K16; busy drops the cycle after.
- Same key with decrypt = 1:
  - First sk = 0xCB3D8B0E17F5 with sk_round = 15; second sk = 0xBF918D3D3F0A (K15).
  - Last sk = 0x1B02EFFC7072 with sk_round = 0 and sk_last = 1.
- Backpressure: encrypt run, sk_ready toggled pseudo-randomly.
  - sk/sk_round stay stable on every stall cycle.
  - The sequence still matches the 16 golden subkeys with no skips or repeats.
- Abort: key_load with a new key (decrypt = 1) while step = 7 of an encrypt run with sk_ready high the same cycle.
  - The next cycle shows K16 of the new key with sk_round = 15; the old schedule never resumes.
- Reset mid-run:
  - rst_n low at step 5 → sk_valid, busy and sk_last are 0 asynchronously.
  - After release, outputs stay idle until key_load.
- Parity insensitivity and round-trip:
  - Flipping all bits 8,16,...,64 of the key yields identical subkeys.
  - The decrypt sequence equals the encrypt sequence reversed, for 100 random keys against the reference model.
